sc2bin_relu_ctrl: RTL and testbench
===================================

Name: sc2bin_relu_ctrl

Overview:
Sequencer for the stochastic-to-binary ReLU activation path.
- On `start`, accepts a bipolar stochastic bitstream of fixed length.
- Counts the ones and converts the count to a signed BITWIDTH-bit binary value.
- Applies ReLU gating under a latched `act_en`.
- Presents the result on a valid/ready output handshake.
- Sits between an SC neuron/accumulator array and the binary activation buffer.

Parameters:
- BITWIDTH, 8, width of the signed binary result and `out_data`.
- LOG_LEN, 8, log2 of the stochastic stream length. L = 2^LOG_LEN bits per conversion, LOG_LEN >= 1.

Ports:
- clk, input, 1, clock. All logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begins a conversion. Sampled only in IDLE.
- act_en, input, 1, activation enable. Latched on the accepted `start`.
- sc_valid, input, 1, `sc_bit` is valid this cycle.
- sc_bit, input, 1, stochastic stream bit.
- sc_ready, output, 1, high while accepting stream bits (ACCUM state).
- busy, output, 1, high in every state except IDLE.
- out_valid, output, 1, `out_data` is valid.
- out_ready, input, 1, consumer accepts `out_data`.
- out_data, output, BITWIDTH, ReLU result, non-negative two's complement.
- out_sat, output, 1, conversion saturated at the positive limit. Qualified by `out_valid`.

Behaviour:
- Reset (synchronous, active-high)
  - State goes to IDLE.
  - sc_ready=0, busy=0, out_valid=0, out_data=0, out_sat=0.
  - Internal ones-count, bit-count and latched act_en are all 0.
  - Reset overrides every other input in the same cycle. Reset mid-conversion discards all partial state; no output is produced.
- States: IDLE, ACCUM, CONVERT, HOLD.
- IDLE
  - start=1: latch act_en, clear ones_cnt (LOG_LEN+1 bits) and bit_cnt (LOG_LEN bits), go to ACCUM.
  - start=0: remain in IDLE.
- ACCUM
  - sc_ready=1.
  - Each cycle with sc_valid=1: ones_cnt += sc_bit and bit_cnt += 1.
  - sc_valid=0 stalls with no state change. No timeout.
  - When the L-th bit is accepted (sc_valid=1 and bit_cnt==L-1): go to CONVERT. sc_ready falls the next cycle.
  - start is ignored.
- CONVERT (exactly 1 cycle)
  - sc_ready=0.
  - v = ones_cnt - 2^(LOG_LEN-1), computed signed at LOG_LEN+2 bits.
  - Saturate v to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]. out_sat=1 iff clipped at the positive limit.
  - ReLU: out_data = (v_sat >= 0 and latched act_en) ? v_sat : 0.
  - out_sat is forced to 0 when the output is zeroed.
  - Register the results, set out_valid=1, go to HOLD.
- HOLD
  - out_valid=1; out_data and out_sat are held stable until the handshake.
  - out_valid & out_ready: next cycle out_valid=0 and state is IDLE. out_data keeps its last value.
  - start during HOLD is ignored. A new start is accepted no earlier than the cycle after return to IDLE.
- Latency
  - Start-to-out_valid = 1 (IDLE→ACCUM) + N_accum cycles (≥ L) + 1 (CONVERT).
  - Minimum is L+2 cycles after the start edge.
- Width rule
  - With LOG_LEN=BITWIDTH, the only clip is at count L (+2^(BITWIDTH-1) → 2^(BITWIDTH-1)-1).
  - If LOG_LEN>BITWIDTH, both ends may clip. A negative clip is then zeroed by ReLU.
- act_en is not resampled after start; changes mid-conversion have no effect.

Test Plan:
- Defaults, start with act_en=1, 256 consecutive sc_bit=1 → out_valid at cycle 258 after start, out_data=127, out_sat=1.
- 192 ones and 64 zeros interleaved, act_en=1 → out_data=64, out_sat=0. The same stream with act_en=0 → out_data=0, out_sat=0.
- All 256 bits zero → v=-128, out_data=0. A stream of exactly 128 ones → out_data=0.
- Stream with random sc_valid gaps (e.g. 40 idle cycles) and 160 ones → out_data=32. ones_cnt is unchanged on gap cycles; sc_ready stays high through the gaps.
- Hold out_ready=0 for 10 cycles in HOLD, toggling start and sc_valid → out_data is stable and no new conversion starts. Release out_ready → IDLE next cycle, busy=0.
- Assert reset after 100 accepted bits → next cycle IDLE with all outputs 0. A following start plus 256 bits with 200 ones → out_data=72, with no carryover from the aborted run.

Source files
------------

// File: rtl/sc2bin_relu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sc2bin_relu_ctrl_if
// Purpose  : Bundles the control, stochastic-stream and result handshake
//            signals of the SC-to-binary ReLU sequencer.
// Signals  : start, act_en      - conversion request and activation enable
//            sc_valid, sc_bit   - stochastic stream input
//            sc_ready           - sequencer is accepting stream bits
//            busy               - sequencer is not idle
//            out_valid/out_ready- result handshake
//            out_data, out_sat  - ReLU result and positive-saturation flag
// Modports : master - producer/consumer side (drives requests, stream, ready)
//            slave  - sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface sc2bin_relu_ctrl_if #(
    parameter int BITWIDTH = 8
);
    logic                start;
    logic                act_en;
    logic                sc_valid;
    logic                sc_bit;
    logic                sc_ready;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] out_data;
    logic                out_sat;

    modport master (
        output start, act_en, sc_valid, sc_bit, out_ready,
        input  sc_ready, busy, out_valid, out_data, out_sat
    );

    modport slave (
        input  start, act_en, sc_valid, sc_bit, out_ready,
        output sc_ready, busy, out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/sc2bin_relu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sc2bin_relu_ctrl
// Purpose  : Accepts a 2^LOG_LEN-bit bipolar stochastic stream, counts its
//            ones, converts the count to a signed BITWIDTH-bit value,
//            applies ReLU gating under the act_en latched at start, and
//            presents the result on a valid/ready handshake.
// Ports    : clk   - clock, rising edge
//            reset - synchronous active-high reset
//            bus   - sc2bin_relu_ctrl_if.slave (control, stream, result)
// Revision : 1.0 - initial release
// ============================================================================
module sc2bin_relu_ctrl #(
    parameter int BITWIDTH = 8,
    parameter int LOG_LEN  = 8
) (
    input  wire                    clk,
    input  wire                    reset,
    sc2bin_relu_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_CONVERT = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // Signed working width: wide enough for the bipolar offset value
    // (LOG_LEN+2 bits) and for the BITWIDTH saturation limits.
    localparam int c_W = ((LOG_LEN + 2) > BITWIDTH ? (LOG_LEN + 2) : BITWIDTH) + 1;

    localparam logic signed [c_W-1:0] c_ONE     = {{(c_W-1){1'b0}}, 1'b1};
    localparam logic signed [c_W-1:0] c_HALF    = c_ONE <<< (LOG_LEN - 1);
    localparam logic signed [c_W-1:0] c_POS_MAX = (c_ONE <<< (BITWIDTH - 1)) - c_ONE;

    state_t                r_state;
    state_t                w_next_state;
    logic [LOG_LEN:0]      r_ones;
    logic [LOG_LEN-1:0]    r_bits;
    logic                  r_act;
    logic [BITWIDTH-1:0]   r_data;
    logic                  r_sat;

    logic signed [c_W-1:0] w_v;
    logic [BITWIDTH-1:0]   w_data;
    logic                  w_sat;
    logic                  w_last_bit;

    // The L-th bit is accepted when the bit counter is all ones.
    assign w_last_bit = bus.sc_valid && (&r_bits);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (bus.start)     w_next_state = S_ACCUM;
            S_ACCUM:   if (w_last_bit)    w_next_state = S_CONVERT;
            S_CONVERT:                    w_next_state = S_HOLD;
            S_HOLD:    if (bus.out_ready) w_next_state = S_IDLE;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Conversion: v = ones - L/2, saturate, then ReLU.
    // A negative value (clipped or not) always ends up as zero after
    // ReLU, so only the positive clip needs an explicit test.
    // ------------------------------------------------------------------
    assign w_v = $signed({{(c_W-LOG_LEN-1){1'b0}}, r_ones}) - c_HALF;

    always_comb begin
        w_data = '0;
        w_sat  = 1'b0;
        if (r_act && !w_v[c_W-1]) begin
            if (w_v > c_POS_MAX) begin
                w_data = c_POS_MAX[BITWIDTH-1:0];
                w_sat  = 1'b1;
            end else begin
                w_data = w_v[BITWIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ones <= '0;
            r_bits <= '0;
            r_act  <= 1'b0;
            r_data <= '0;
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_act  <= bus.act_en;
                        r_ones <= '0;
                        r_bits <= '0;
                    end
                end
                S_ACCUM: begin
                    if (bus.sc_valid) begin
                        r_ones <= r_ones + {{LOG_LEN{1'b0}}, bus.sc_bit};
                        r_bits <= r_bits + {{(LOG_LEN-1){1'b0}}, 1'b1};
                    end
                end
                S_CONVERT: begin
                    r_data <= w_data;
                    r_sat  <= w_sat;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sc_ready  = (r_state == S_ACCUM);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_sc2bin_relu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc2bin_relu_ctrl
// Purpose  : Self-checking bench for sc2bin_relu_ctrl (BITWIDTH=8, LOG_LEN=8).
//            Table of directed conversions plus hand-written sequences for
//            the HOLD stall and the mid-conversion reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc2bin_relu_ctrl;
    localparam int BW = 8;
    localparam int LL = 8;
    localparam int L  = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sc2bin_relu_ctrl_if #(.BITWIDTH(BW)) bus ();

    sc2bin_relu_ctrl #(.BITWIDTH(BW), .LOG_LEN(LL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic       act;
        int         ones;
        int         gaps;
        logic [7:0] exp_data;
        logic       exp_sat;
    } vec_t;

    vec_t vecs[9];

    // One full conversion. Inputs are driven and outputs sampled on the
    // falling edge. 'edges' counts rising edges from the cycle in which
    // start is presented (that cycle is cycle 1), so out_valid is expected
    // in cycle L+2 plus any stall cycles.
    task automatic run_conv(input logic act, input int ones, input int gaps,
                            input logic [7:0] exp_d, input logic exp_s, input bit ack);
        int   edges;
        int   gd;
        logic b;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.act_en = act;
        edges      = 1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.act_en = ~act;      // must have no effect once latched
        chk("sc_ready_accum", {31'd0, bus.sc_ready}, 32'd1);
        gd = 0;
        for (int i = 0; i < L; i++) begin
            if ((i % 6 == 3) && (gd < gaps)) begin
                bus.sc_valid = 1'b0;
                bus.sc_bit   = 1'b1;   // ignored: must not be counted
                @(negedge clk);
                edges++;
                gd++;
                chk("sc_ready_gap", {31'd0, bus.sc_ready}, 32'd1);
            end
            b = (((i + 1) * ones) / L) != ((i * ones) / L);
            bus.sc_valid = 1'b1;
            bus.sc_bit   = b;
            @(negedge clk);
            edges++;
        end
        bus.sc_valid = 1'b0;
        bus.sc_bit   = 1'b0;
        chk("sc_ready_convert", {31'd0, bus.sc_ready}, 32'd0);
        chk("busy_convert", {31'd0, bus.busy}, 32'd1);
        while (!bus.out_valid && edges < L + gaps + 20) begin
            @(negedge clk);
            edges++;
        end
        chk("latency", edges, L + 2 + gaps);
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_d});
        chk("out_sat", {31'd0, bus.out_sat}, {31'd0, exp_s});
        if (ack) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("valid_drop", {31'd0, bus.out_valid}, 32'd0);
            chk("busy_drop", {31'd0, bus.busy}, 32'd0);
            chk("data_kept", {24'd0, bus.out_data}, {24'd0, exp_d});
        end
    endtask

    initial begin
        //            act   ones gaps data  sat
        vecs[0] = '{1'b1, 256,  0, 8'd127, 1'b1};
        vecs[1] = '{1'b1, 192,  0, 8'd64,  1'b0};
        vecs[2] = '{1'b0, 192,  0, 8'd0,   1'b0};
        vecs[3] = '{1'b1,   0,  0, 8'd0,   1'b0};
        vecs[4] = '{1'b1, 128,  0, 8'd0,   1'b0};
        vecs[5] = '{1'b1, 160, 40, 8'd32,  1'b0};
        vecs[6] = '{1'b1, 129,  0, 8'd1,   1'b0};
        vecs[7] = '{1'b1, 255,  0, 8'd127, 1'b0};
        vecs[8] = '{1'b0, 256,  0, 8'd0,   1'b0};

        reset         = 1'b1;
        bus.start     = 1'b1;   // reset must win over start
        bus.act_en    = 1'b1;
        bus.sc_valid  = 1'b1;
        bus.sc_bit    = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sc_ready",  {31'd0, bus.sc_ready},  32'd0);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, bus.out_data},  32'd0);
        chk("rst_out_sat",   {31'd0, bus.out_sat},   32'd0);
        bus.start    = 1'b0;
        bus.sc_valid = 1'b0;
        bus.sc_bit   = 1'b0;
        reset        = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_conv(vecs[v].act, vecs[v].ones, vecs[v].gaps,
                     vecs[v].exp_data, vecs[v].exp_sat, 1'b1);
        end

        // HOLD stall: result stays put, start and stream are ignored.
        run_conv(1'b1, 192, 0, 8'd64, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bus.start    = (k % 2 == 0);
            bus.sc_valid = 1'b1;
            bus.sc_bit   = 1'b1;
            @(negedge clk);
            chk("hold_valid",    {31'd0, bus.out_valid}, 32'd1);
            chk("hold_data",     {24'd0, bus.out_data},  32'd64);
            chk("hold_sc_ready", {31'd0, bus.sc_ready},  32'd0);
        end
        bus.start     = 1'b0;
        bus.sc_valid  = 1'b0;
        bus.sc_bit    = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_busy",  {31'd0, bus.busy},      32'd0);
        chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("idle_stays",    {31'd0, bus.busy},      32'd0);

        // Reset after 100 accepted bits, then a clean conversion.
        bus.start  = 1'b1;
        bus.act_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.sc_valid = 1'b1;
            bus.sc_bit   = 1'b1;
            @(negedge clk);
        end
        reset        = 1'b1;
        bus.sc_valid = 1'b0;
        bus.sc_bit   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy",      {31'd0, bus.busy},      32'd0);
        chk("abort_sc_ready",  {31'd0, bus.sc_ready},  32'd0);
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_out_data",  {24'd0, bus.out_data},  32'd0);
        chk("abort_out_sat",   {31'd0, bus.out_sat},   32'd0);
        run_conv(1'b1, 200, 0, 8'd72, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
